// File: rtl/threshold_cutter_writer.sv
// Threshold-triggered segment writer: cuts fixed-length blocks into a ring of RAM blocks.
// Optional CUTTER_HOLDOFF_EN: ignore triggers for HOLDOFF_LEN valid samples after each commit.
module threshold_cutter_writer #(
    parameter int BLOCK_NUM_INDEX   = 6,
    parameter int BLOCK_DEPTH_INDEX = 9,
    parameter int BLOCK_WIDTH       = 32,
    parameter int HOLDOFF_LEN       = 256
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     cut_en,
    input  logic [BLOCK_WIDTH-1:0]                   threshold,
    input  logic                                     sample_valid,
    input  logic [BLOCK_WIDTH-1:0]                   sample_data,
    input  logic                                     block_release,
    output logic                                     bram_wen,
    output logic [BLOCK_WIDTH-1:0]                   bram_data_i,
    output logic [BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX-1:0] bram_waddr,
    output logic                                     block_done,
    output logic [BLOCK_NUM_INDEX-1:0]               done_block_idx,
    output logic [BLOCK_NUM_INDEX:0]                 blocks_used,
    output logic                                     ring_full,
    output logic                                     overflow
);
    localparam int NI = BLOCK_NUM_INDEX;
    localparam int DI = BLOCK_DEPTH_INDEX;
    localparam int W  = BLOCK_WIDTH;
    localparam logic [DI-1:0] LAST_WORD = '1;
    localparam logic [DI-1:0] PTR_ONE   = DI'(1);
    localparam logic [NI-1:0] BLK_ONE   = NI'(1);
    localparam logic [NI:0]   USED_ONE  = (NI+1)'(1);
    localparam logic [NI:0]   USED_FULL = {1'b1, {NI{1'b0}}};
    localparam logic [W:0]    MAG_ONE   = (W+1)'(1);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLDOFF} state_e;

    state_e                state_q, state_d;
    logic [NI-1:0]         wr_blk_q, wr_blk_d;
    logic [DI-1:0]         wr_ptr_q, wr_ptr_d;
    logic [NI-1:0]         rd_blk_q, rd_blk_d;
    logic [NI:0]           used_q, used_d;
    logic                  ovf_q, ovf_d;
    logic                  wen_q, wen_d;
    logic [NI+DI-1:0]      waddr_q, waddr_d;
    logic [W-1:0]          wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic [NI-1:0]         done_idx_q, done_idx_d;
    logic                  commit, release_ok;
    logic [W:0]            mag;
    logic                  trigger;
    logic                  unused_ok;

    // One extra bit keeps |most-negative| representable.
    assign mag       = sample_data[W-1] ? ({1'b0, ~sample_data} + MAG_ONE) : {1'b0, sample_data};
    assign trigger   = sample_valid & cut_en & (mag >= {1'b0, threshold});
    assign ring_full = (used_q == USED_FULL);

`ifdef CUTTER_HOLDOFF_EN
    localparam int HW = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_LEN - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt_q <= '0;
        else        hold_cnt_q <= hold_cnt_d;
    end
    assign unused_ok = ^rd_blk_q;
`else
    assign unused_ok = ^{rd_blk_q, HOLDOFF_LEN[0]};
`endif

    always_comb begin
        state_d    = state_q;
        wr_blk_d   = wr_blk_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        done_idx_d = done_idx_q;
        commit     = 1'b0;
`ifdef CUTTER_HOLDOFF_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (ring_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wen_d    = 1'b1;
                        waddr_d  = {wr_blk_q, wr_ptr_q};
                        wdata_d  = sample_data;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d  = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!cut_en) begin
                    // Abort: partial words stay in RAM and get overwritten later.
                    wr_ptr_d = '0;
                    state_d  = IDLE;
                end else if (sample_valid) begin
                    wen_d   = 1'b1;
                    waddr_d = {wr_blk_q, wr_ptr_q};
                    wdata_d = sample_data;
                    if (wr_ptr_q == LAST_WORD) begin
                        commit     = 1'b1;
                        done_d     = 1'b1;
                        done_idx_d = wr_blk_q;
                        wr_blk_d   = wr_blk_q + BLK_ONE;
                        wr_ptr_d   = '0;
`ifdef CUTTER_HOLDOFF_EN
                        hold_cnt_d = '0;
                        state_d    = HOLDOFF;
`else
                        state_d    = IDLE;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
`ifdef CUTTER_HOLDOFF_EN
            HOLDOFF: begin
                if (!cut_en) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if (sample_valid) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A release arriving with a commit cancels it out in the occupancy count.
    always_comb begin
        release_ok = block_release & (used_q != '0);
        used_d     = used_q;
        rd_blk_d   = rd_blk_q;
        if (release_ok) rd_blk_d = rd_blk_q + BLK_ONE;
        case ({commit, release_ok})
            2'b10:   used_d = used_q + USED_ONE;
            2'b01:   used_d = used_q - USED_ONE;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_blk_q   <= '0;
            wr_ptr_q   <= '0;
            rd_blk_q   <= '0;
            used_q     <= '0;
            ovf_q      <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            done_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_blk_q   <= wr_blk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_blk_q   <= rd_blk_d;
            used_q     <= used_d;
            ovf_q      <= ovf_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            done_idx_q <= done_idx_d;
        end
    end

    assign bram_wen       = wen_q;
    assign bram_waddr     = waddr_q;
    assign bram_data_i    = wdata_q;
    assign block_done     = done_q;
    assign done_block_idx = done_idx_q;
    assign blocks_used    = used_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_threshold_cutter_writer.sv
// Bench for threshold_cutter_writer: vector table with per-cycle expected outputs via a scoreboard queue.
module tb_threshold_cutter_writer;
    localparam int NI = 2;
    localparam int DI = 3;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cut_en = 1'b1;
    logic [W-1:0]  threshold = 32'd100;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  sample_data = '0;
    logic          block_release = 1'b0;
    logic          bram_wen;
    logic [W-1:0]  bram_data_i;
    logic [NI+DI-1:0] bram_waddr;
    logic          block_done;
    logic [NI-1:0] done_block_idx;
    logic [NI:0]   blocks_used;
    logic          ring_full;
    logic          overflow;

    threshold_cutter_writer #(
        .BLOCK_NUM_INDEX(NI), .BLOCK_DEPTH_INDEX(DI), .BLOCK_WIDTH(W), .HOLDOFF_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cut_en(cut_en), .threshold(threshold),
        .sample_valid(sample_valid), .sample_data(sample_data), .block_release(block_release),
        .bram_wen(bram_wen), .bram_data_i(bram_data_i), .bram_waddr(bram_waddr),
        .block_done(block_done), .done_block_idx(done_block_idx), .blocks_used(blocks_used),
        .ring_full(ring_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sv;
        logic [31:0] d;
        bit          en;
        bit          rel;
        bit          wen;
        logic [4:0]  addr;
        logic [31:0] wd;
        bit          done;
        logic [1:0]  idx;
        logic [2:0]  used;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit sv, input logic [31:0] d, input bit en, input bit rel,
                       input bit wen, input logic [4:0] addr, input logic [31:0] wd,
                       input bit done, input logic [1:0] idx, input logic [2:0] used, input bit ovf);
        vec_t v;
        v.sv = sv; v.d = d; v.en = en; v.rel = rel; v.wen = wen; v.addr = addr; v.wd = wd;
        v.done = done; v.idx = idx; v.used = used; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    // Full block: trigger word d0, then words 1..7; optional 4 quiet samples afterwards.
    task automatic blk(input logic [1:0] b, input logic [31:0] d0, input logic [2:0] ub,
                       input logic [2:0] ua, input bit ovf, input bit rel_last, input bit pad);
        logic [2:0] k;
        add(1, d0, 1, 0, 1, {b, 3'd0}, d0, 0, 0, ub, ovf);
        for (int i = 1; i < 8; i++) begin
            k = 3'(i);
            if (i == 7) add(1, 32'(i), 1, rel_last, 1, {b, k}, 32'(i), 1, b, ua, ovf);
            else        add(1, 32'(i), 1, 0, 1, {b, k}, 32'(i), 0, 0, ub, ovf);
        end
        if (pad) for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 0, 0, 0, 0, ua, ovf);
    endtask

    task automatic run();
        foreach (vecs[i]) begin
            @(negedge clk);
            sample_valid  = vecs[i].sv;
            sample_data   = vecs[i].d;
            cut_en        = vecs[i].en;
            block_release = vecs[i].rel;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        sample_valid = 1'b0; block_release = 1'b0; cut_en = 1'b1;
        @(posedge clk); #3;
        vecs.delete();
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        cmp({nm, ".wen"}, 32'(bram_wen), 0);
        cmp({nm, ".addr"}, 32'(bram_waddr), 0);
        cmp({nm, ".data"}, bram_data_i, 0);
        cmp({nm, ".done"}, 32'(block_done), 0);
        cmp({nm, ".idx"}, 32'(done_block_idx), 0);
        cmp({nm, ".used"}, 32'(blocks_used), 0);
        cmp({nm, ".full"}, 32'(ring_full), 0);
        cmp({nm, ".ovf"}, 32'(overflow), 0);
    endtask

    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            cmp("wen", 32'(bram_wen), 32'(e.wen));
            if (e.wen) begin
                cmp("waddr", 32'(bram_waddr), 32'(e.addr));
                cmp("wdata", bram_data_i, e.wd);
            end
            cmp("block_done", 32'(block_done), 32'(e.done));
            if (e.done) cmp("done_idx", 32'(done_block_idx), 32'(e.idx));
            cmp("blocks_used", 32'(blocks_used), 32'(e.used));
            cmp("ring_full", 32'(ring_full), 32'(e.used == 3'd4));
            cmp("overflow", 32'(overflow), 32'(e.ovf));
        end
    end

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Below-threshold samples, then capture of block 0 on -150.
        add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, -20, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        blk(0, -150, 0, 1, 0, 0, 1);
        // Most-negative sample triggers.
        blk(1, 32'h8000_0000, 1, 2, 0, 0, 1);
        blk(2, 300, 2, 3, 0, 0, 1);
        blk(3, -300, 3, 4, 0, 0, 1);
        // Ring full: trigger dropped, overflow set.
        add(1, 200, 1, 0, 0, 0, 0, 0, 0, 4, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 1);
        blk(0, 200, 3, 4, 1, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        // Abort after 3 words in block 1.
        add(1, 400, 1, 0, 1, 5'd8, 400, 0, 0, 1, 1);
        add(1, 1, 1, 0, 1, 5'd9, 1, 0, 0, 1, 1);
        add(1, 2, 1, 0, 1, 5'd10, 2, 0, 0, 1, 1);
        add(1, 500, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        // Recapture block 1 from word 0; release coincides with commit.
        blk(1, -400, 1, 1, 1, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        // cut_en low in IDLE and |x| just under threshold: nothing.
        add(1, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, -99, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        // Magnitude equal to threshold triggers.
        blk(2, 100, 0, 1, 1, 0, 1);
`ifdef CUTTER_HOLDOFF_EN
        blk(3, 200, 1, 2, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 200, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        blk(0, 250, 2, 3, 1, 0, 1);
`endif
        run();

        // Async reset in the middle of a capture.
        @(negedge clk);
        sample_valid = 1'b1; sample_data = 150;
        @(negedge clk);
        sample_data = 1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n = 1'b1;
        add(1, 150, 1, 0, 1, 5'd0, 150, 0, 0, 0, 0);
        add(1, 9, 1, 0, 1, 5'd1, 9, 0, 0, 0, 0);
        run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
